computer_top: RTL and testbench

Top-level 8-bit SAP-2 style computer: a multi-cycle accumulator CPU (`u_cpu`, containing `u_control_unit`), a program ROM (`u_rom`) and a data RAM (`u_ram`) on a shared 16-bit address / 8-bit data bus. The block is self-contained: after reset it fetches and executes from ROM until a `HLT` instruction, and it is observed only through its internal hierarchy.

---
 rtl/computer_top.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_computer_top.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/computer_top.sv
// computer_top: 8-bit SAP-2 style accumulator computer.
//   u_cpu (with u_control_unit), 4 KiB program ROM at 0xF000, 256 B data RAM at 0x0000,
//   sharing a 16-bit address / 8-bit data bus. Runs from ROM after reset until HLT.
// Ports:
//   clk   - system clock, rising-edge active
//   reset - asynchronous active-low reset
// Optional macro SAP2_SIM_TASKS_EN: adds simulation helper tasks to the memories
//   (u_rom.init_sim_rom, u_rom.dump, u_ram.init_sim_ram); logic is otherwise identical.

package arch_defs_pkg;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 16;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h01;
    localparam logic [7:0] OP_LDI_A = 8'h10;
    localparam logic [7:0] OP_LDA   = 8'h11;
    localparam logic [7:0] OP_STA   = 8'h12;
    localparam logic [7:0] OP_RAR   = 8'h20;
    localparam logic [7:0] OP_RAL   = 8'h21;
    localparam logic [7:0] OP_CMA   = 8'h22;

    localparam logic [15:0] PC_RESET = 16'hF000;

    typedef enum logic [4:0] {
        StInit, StF0, StF1, StF2, StChk,
        StOp10, StOp11, StOp12, StOp13,
        StOp20, StOp21, StOp22, StOp23,
        StEx0, StEx1, StEx2, StLatch, StHalt
    } ctrl_state_e;
endpackage

// control_unit: sequences fetch, operand fetch and execute microsteps; emits datapath strobes.
module control_unit
    import arch_defs_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_opcode,
    output logic                  o_mar_pc,
    output logic                  o_mar_tmp,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic                  o_ir_ld,
    output logic                  o_pc_inc,
    output logic                  o_t1_ld,
    output logic                  o_t2_ld,
    output logic                  o_a_imm,
    output logic                  o_a_mem,
    output logic                  o_rar,
    output logic                  o_ral,
    output logic                  o_cma,
    output logic                  o_halt_set
);
    ctrl_state_e r_state;
    ctrl_state_e w_state_next;
    logic [DATA_WIDTH-1:0] opcode;
    logic [1:0] w_nbytes;
    logic [1:0] w_steps;

    assign opcode = i_opcode;

    always_comb begin
        w_nbytes = 2'd0;
        w_steps  = 2'd1;
        case (opcode)
            OP_LDI_A:                w_nbytes = 2'd1;
            OP_LDA, OP_STA:          begin w_nbytes = 2'd2; w_steps = 2'd3; end
            OP_RAR, OP_RAL, OP_CMA:  w_steps = 2'd2;
            default:                 ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StInit;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_mar_pc = 1'b0; o_mar_tmp = 1'b0; o_mem_re = 1'b0; o_mem_we = 1'b0;
        o_ir_ld  = 1'b0; o_pc_inc  = 1'b0; o_t1_ld  = 1'b0; o_t2_ld  = 1'b0;
        o_a_imm  = 1'b0; o_a_mem   = 1'b0; o_rar    = 1'b0; o_ral    = 1'b0;
        o_cma    = 1'b0; o_halt_set = 1'b0;
        case (r_state)
            StInit: w_state_next = StF0;
            StF0:   begin o_mar_pc = 1'b1; w_state_next = StF1; end
            StF1:   begin o_mem_re = 1'b1; w_state_next = StF2; end
            StF2:   begin o_ir_ld = 1'b1; o_pc_inc = 1'b1; w_state_next = StChk; end
            StChk: begin
                if (opcode == OP_HLT) begin
                    o_halt_set   = 1'b1;
                    w_state_next = StHalt;
                end else if (w_nbytes != 2'd0) begin
                    w_state_next = StOp10;
                end else begin
                    w_state_next = StEx0;
                end
            end
            StOp10: begin o_mar_pc = 1'b1; w_state_next = StOp11; end
            StOp11: begin o_mem_re = 1'b1; w_state_next = StOp12; end
            StOp12: begin o_t1_ld = 1'b1; o_pc_inc = 1'b1; w_state_next = StOp13; end
            StOp13: w_state_next = (w_nbytes == 2'd2) ? StOp20 : StEx0;
            StOp20: begin o_mar_pc = 1'b1; w_state_next = StOp21; end
            StOp21: begin o_mem_re = 1'b1; w_state_next = StOp22; end
            StOp22: begin o_t2_ld = 1'b1; o_pc_inc = 1'b1; w_state_next = StOp23; end
            StOp23: w_state_next = StEx0;
            StEx0: begin
                case (opcode)
                    OP_LDI_A:       o_a_imm   = 1'b1;
                    OP_LDA, OP_STA: o_mar_tmp = 1'b1;
                    default:        ;
                endcase
                w_state_next = (w_steps == 2'd1) ? StLatch : StEx1;
            end
            StEx1: begin
                case (opcode)
                    OP_LDA:  o_mem_re = 1'b1;
                    OP_STA:  o_mem_we = 1'b1;
                    OP_RAR:  o_rar    = 1'b1;
                    OP_RAL:  o_ral    = 1'b1;
                    OP_CMA:  o_cma    = 1'b1;
                    default: ;
                endcase
                w_state_next = (w_steps == 2'd2) ? StLatch : StEx2;
            end
            StEx2: begin
                if (opcode == OP_LDA) o_a_mem = 1'b1;
                w_state_next = StLatch;
            end
            StLatch: w_state_next = StF0;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StInit;
        endcase
    end
endmodule

// cpu: accumulator datapath (PC, MAR, IR, A, temp_1/2, Z/N/C flags, halt) plus control unit.
//   i_rdata - registered read data from the bus; o_addr/o_wdata/o_re/o_we - bus master side.
module cpu
    import arch_defs_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_re,
    output logic                  o_we
);
    // Architectural registers keep their observable names.
    logic [ADDR_WIDTH-1:0] counter_out, r_mar;
    logic [DATA_WIDTH-1:0] opcode, a_out, temp_1_out, r_temp_2;
    logic                  flag_zero_o, flag_negative_o, flag_carry_o, halt;

    logic [ADDR_WIDTH-1:0] w_pc_next, w_mar_next;
    logic [DATA_WIDTH-1:0] w_ir_next, w_a_next, w_t1_next, w_t2_next;
    logic                  w_z_next, w_n_next, w_c_next, w_halt_next;
    logic w_mar_pc, w_mar_tmp, w_ir_ld, w_pc_inc, w_t1_ld, w_t2_ld;
    logic w_a_imm, w_a_mem, w_rar, w_ral, w_cma, w_halt_set;

    control_unit u_control_unit (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_opcode   (opcode),
        .o_mar_pc   (w_mar_pc),
        .o_mar_tmp  (w_mar_tmp),
        .o_mem_re   (o_re),
        .o_mem_we   (o_we),
        .o_ir_ld    (w_ir_ld),
        .o_pc_inc   (w_pc_inc),
        .o_t1_ld    (w_t1_ld),
        .o_t2_ld    (w_t2_ld),
        .o_a_imm    (w_a_imm),
        .o_a_mem    (w_a_mem),
        .o_rar      (w_rar),
        .o_ral      (w_ral),
        .o_cma      (w_cma),
        .o_halt_set (w_halt_set)
    );

    assign o_addr  = r_mar;
    assign o_wdata = a_out;

    always_comb begin
        w_pc_next = counter_out; w_mar_next = r_mar; w_ir_next = opcode;
        w_t1_next = temp_1_out;  w_t2_next = r_temp_2; w_a_next = a_out;
        w_z_next  = flag_zero_o; w_n_next = flag_negative_o; w_c_next = flag_carry_o;
        w_halt_next = halt;
        if (w_mar_pc)       w_mar_next = counter_out;
        else if (w_mar_tmp) w_mar_next = {r_temp_2, temp_1_out};
        if (w_pc_inc) w_pc_next = counter_out + 16'd1;  // wraps 0xFFFF -> 0x0000
        if (w_ir_ld)  w_ir_next = i_rdata;
        if (w_t1_ld)  w_t1_next = i_rdata;
        if (w_t2_ld)  w_t2_next = i_rdata;
        if (w_a_imm) begin
            w_a_next = temp_1_out;
            w_z_next = (temp_1_out == 8'h00);
            w_n_next = temp_1_out[7];
        end
        if (w_a_mem) begin
            w_a_next = i_rdata;
            w_z_next = (i_rdata == 8'h00);
            w_n_next = i_rdata[7];
        end
        // Rotates go through carry as a 9-bit ring.
        if (w_rar) begin
            w_a_next = {flag_carry_o, a_out[7:1]};
            w_c_next = a_out[0];
        end
        if (w_ral) begin
            w_a_next = {a_out[6:0], flag_carry_o};
            w_c_next = a_out[7];
        end
        if (w_cma) begin
            w_a_next = ~a_out;
            w_z_next = (a_out == 8'hFF);
            w_n_next = ~a_out[7];
        end
        if (w_halt_set) w_halt_next = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counter_out <= PC_RESET; r_mar <= '0; opcode <= '0; a_out <= '0;
            temp_1_out <= '0; r_temp_2 <= '0; flag_zero_o <= 1'b0;
            flag_negative_o <= 1'b0; flag_carry_o <= 1'b0; halt <= 1'b0;
        end else begin
            counter_out <= w_pc_next; r_mar <= w_mar_next; opcode <= w_ir_next;
            a_out <= w_a_next; temp_1_out <= w_t1_next; r_temp_2 <= w_t2_next;
            flag_zero_o <= w_z_next; flag_negative_o <= w_n_next;
            flag_carry_o <= w_c_next; halt <= w_halt_next;
        end
    end
endmodule

// rom: 4 KiB program store, synchronous read (1-cycle latency), no write port.
module rom (
    input  logic        i_clk,
    input  logic        i_en,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_rdata
);
    logic [7:0] mem [0:4095];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) r_rdata <= mem[i_addr];
    end
    assign o_rdata = r_rdata;

`ifdef SAP2_SIM_TASKS_EN
    task automatic init_sim_rom();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask

    task automatic dump();
        for (int i = 0; i < 4096; i++)
            if (mem[i] != 8'h00) $display("rom %h: %h", 16'hF000 + 16'(i), mem[i]);
    endtask
`else
`endif
endmodule

// ram: 256 B data store, synchronous read (1-cycle latency) and write.
module ram (
    input  logic       i_clk,
    input  logic       i_re,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);
    logic [7:0] mem [0:255];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= mem[i_addr];
    end
    assign o_rdata = r_rdata;

`ifdef SAP2_SIM_TASKS_EN
    task automatic init_sim_ram();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask
`else
`endif
endmodule

module computer_top (
    input logic clk,
    input logic reset
);
    typedef enum logic [1:0] {SrcNone, SrcRom, SrcRam} rd_src_e;

    logic [15:0] w_addr;
    logic [7:0]  w_wdata, w_rdata, w_rom_rdata, w_ram_rdata;
    logic        w_re, w_we, w_rom_sel, w_ram_sel, w_ram_we;
    rd_src_e     r_rd_src;

    assign w_rom_sel = (w_addr[15:12] == 4'hF);
    assign w_ram_sel = (w_addr[15:8] == 8'h00);
    assign w_ram_we  = w_we & w_ram_sel;  // ROM and unmapped writes are dropped

    cpu u_cpu (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_rdata (w_rdata),
        .o_addr  (w_addr),
        .o_wdata (w_wdata),
        .o_re    (w_re),
        .o_we    (w_we)
    );

    rom u_rom (
        .i_clk   (clk),
        .i_en    (w_re & w_rom_sel),
        .i_addr  (w_addr[11:0]),
        .o_rdata (w_rom_rdata)
    );

    ram u_ram (
        .i_clk   (clk),
        .i_re    (w_re & w_ram_sel),
        .i_we    (w_ram_we),
        .i_addr  (w_addr[7:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Remember which device the last read targeted so unmapped reads return 0x00.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rd_src <= SrcNone;
        else if (w_re) r_rd_src <= w_rom_sel ? SrcRom : (w_ram_sel ? SrcRam : SrcNone);
    end

    always_comb begin
        w_rdata = 8'h00;
        case (r_rd_src)
            SrcRom:  w_rdata = w_rom_rdata;
            SrcRam:  w_rdata = w_ram_rdata;
            default: w_rdata = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_computer_top.sv
module tb_computer_top;
    import arch_defs_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic       z;
        logic       n;
        logic       c;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];
    logic [7:0] prog[$];

    computer_top dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every LATCH cycle retires one instruction; compare A and flags.
    always @(negedge clk) begin
        if (reset && dut.u_cpu.u_control_unit.r_state == StLatch) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: instruction retired with no expectation at %0t",
                         $time);
            end else begin
                exp_t e;
                exp_t o;
                e = sb_q.pop_front();
                o = '{a: dut.u_cpu.a_out, z: dut.u_cpu.flag_zero_o,
                      n: dut.u_cpu.flag_negative_o, c: dut.u_cpu.flag_carry_o};
                if (o !== e) begin
                    n_err++;
                    $display("FAIL sb_retire: got A=%h Z=%b N=%b C=%b want A=%h Z=%b N=%b C=%b",
                             o.a, o.z, o.n, o.c, e.a, e.z, e.n, e.c);
                end
            end
        end
    end

    task automatic load_and_release();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) dut.u_rom.mem[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) dut.u_rom.mem[i] = prog[i];
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int limit);
        for (int i = 0; i < limit && dut.u_cpu.halt !== 1'b1; i++) @(negedge clk);
        n_vec++;
        if (dut.u_cpu.halt !== 1'b1) begin
            n_err++;
            $display("FAIL %s_halt_timeout: halt=%b want 1", name, dut.u_cpu.halt);
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_sb_pending: %0d left want 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.temp_1_out, dut.u_cpu.opcode}
            !== {16'hF000, 8'h00, 8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL reset_regs: pc=%h a=%h t1=%h op=%h want f000 00 00 00",
                     dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.temp_1_out,
                     dut.u_cpu.opcode);
        end
        n_vec++;
        if ({dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o,
             dut.u_cpu.halt} !== 4'b0000 || dut.u_cpu.u_control_unit.r_state !== StInit) begin
            n_err++;
            $display("FAIL reset_flags: znch=%b%b%b%b state=%0d want 0000 INIT",
                     dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                     dut.u_cpu.flag_carry_o, dut.u_cpu.halt,
                     dut.u_cpu.u_control_unit.r_state);
        end
    endtask

    task automatic test_ldi_rar_hlt();
        prog = '{8'h10, 8'hF0, 8'h20, 8'h01};
        sb_q.push_back('{a: 8'hF0, z: 1'b0, n: 1'b1, c: 1'b0});
        sb_q.push_back('{a: 8'h78, z: 1'b0, n: 1'b1, c: 1'b0});
        load_and_release();
        wait_halt("ldi_rar", 200);
        n_vec++;
        if ({dut.u_cpu.opcode, dut.u_cpu.u_control_unit.opcode, dut.u_cpu.counter_out}
            !== {8'h01, 8'h01, 16'hF004}) begin
            n_err++;
            $display("FAIL ldi_rar_at_hlt: op=%h cu_op=%h pc=%h want 01 01 f004",
                     dut.u_cpu.opcode, dut.u_cpu.u_control_unit.opcode,
                     dut.u_cpu.counter_out);
        end
    endtask

    task automatic test_cycle_timing();
        logic [7:0] got;
        logic [7:0] want;
        string      what;
        prog = '{8'h10, 8'hF0, 8'h20, 8'h01};
        sb_q.push_back('{a: 8'hF0, z: 1'b0, n: 1'b1, c: 1'b0});
        sb_q.push_back('{a: 8'h78, z: 1'b0, n: 1'b1, c: 1'b0});
        load_and_release();
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk);
            #1;
            what = "";
            case (e)
                5:  begin what = "op_ldi";   got = dut.u_cpu.opcode;     want = 8'h10; end
                9:  begin what = "temp1";    got = dut.u_cpu.temp_1_out; want = 8'hF0; end
                11: begin what = "a_ldi";    got = dut.u_cpu.a_out;      want = 8'hF0; end
                13: begin what = "op_hold";  got = dut.u_cpu.opcode;     want = 8'h10; end
                14: begin what = "op_rar";   got = dut.u_cpu.opcode;     want = 8'h20; end
                16: begin what = "a_pre";    got = dut.u_cpu.a_out;      want = 8'hF0; end
                17: begin what = "a_rar";    got = dut.u_cpu.a_out;      want = 8'h78; end
                20: begin what = "op_hold2"; got = dut.u_cpu.opcode;     want = 8'h20; end
                21: begin what = "op_hlt";   got = dut.u_cpu.opcode;     want = 8'h01; end
                default: ;
            endcase
            if (what != "") begin
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL cyc_%s edge %0d: got %h want %h", what, e, got, want);
                end
            end
        end
        wait_halt("cycle", 50);
    endtask

    task automatic test_rotate_carry();
        // LDI 01; RAR; RAL; CMA; unknown 0x77 (NOP); HLT
        prog = '{8'h10, 8'h01, 8'h20, 8'h21, 8'h22, 8'h77, 8'h01};
        sb_q.push_back('{a: 8'h01, z: 1'b0, n: 1'b0, c: 1'b0});
        sb_q.push_back('{a: 8'h00, z: 1'b0, n: 1'b0, c: 1'b1});
        sb_q.push_back('{a: 8'h01, z: 1'b0, n: 1'b0, c: 1'b0});
        sb_q.push_back('{a: 8'hFE, z: 1'b0, n: 1'b1, c: 1'b0});
        sb_q.push_back('{a: 8'hFE, z: 1'b0, n: 1'b1, c: 1'b0});
        load_and_release();
        wait_halt("rotate", 300);
        n_vec++;
        if (dut.u_cpu.counter_out !== 16'hF007) begin
            n_err++;
            $display("FAIL rotate_pc: got %h want f007", dut.u_cpu.counter_out);
        end
    endtask

    task automatic test_sta_lda();
        // LDI 5A; STA 0010; LDI 00; LDA 0010; HLT
        prog = '{8'h10, 8'h5A, 8'h12, 8'h10, 8'h00, 8'h10, 8'h00, 8'h11, 8'h10, 8'h00, 8'h01};
        sb_q.push_back('{a: 8'h5A, z: 1'b0, n: 1'b0, c: 1'b0});
        sb_q.push_back('{a: 8'h5A, z: 1'b0, n: 1'b0, c: 1'b0});
        sb_q.push_back('{a: 8'h00, z: 1'b1, n: 1'b0, c: 1'b0});
        sb_q.push_back('{a: 8'h5A, z: 1'b0, n: 1'b0, c: 1'b0});
        load_and_release();
        wait_halt("sta_lda", 300);
        n_vec++;
        if (dut.u_ram.mem[16] !== 8'h5A) begin
            n_err++;
            $display("FAIL sta_ram: got %h want 5a", dut.u_ram.mem[16]);
        end
        n_vec++;
        if (dut.u_cpu.counter_out !== 16'hF00B) begin
            n_err++;
            $display("FAIL sta_lda_pc: got %h want f00b", dut.u_cpu.counter_out);
        end
    endtask

    task automatic test_halt_hold();
        // Continues from the halted STA/LDA program.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if ({dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.flag_zero_o,
                 dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o, dut.w_ram_we}
                !== {16'hF00B, 8'h5A, 4'b0000}) begin
                n_err++;
                $display("FAIL halt_hold cyc %0d: pc=%h a=%h znc=%b%b%b we=%b want f00b 5a 000 0",
                         i, dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.flag_zero_o,
                         dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o, dut.w_ram_we);
            end
        end
        n_vec++;
        if (dut.u_ram.mem[16] !== 8'h5A) begin
            n_err++;
            $display("FAIL halt_ram: got %h want 5a", dut.u_ram.mem[16]);
        end
    endtask

    task automatic test_reset_mid_rar();
        bit found;
        prog = '{8'h10, 8'hF0, 8'h20, 8'h01};
        sb_q.push_back('{a: 8'hF0, z: 1'b0, n: 1'b1, c: 1'b0});
        load_and_release();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #2;
            if (dut.u_cpu.u_control_unit.r_state == StEx1 && dut.u_cpu.opcode == OP_RAR)
                found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL midrar_reach: got not-found want RAR EX1");
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.flag_zero_o,
             dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o, dut.u_cpu.halt}
            !== {16'hF000, 8'h00, 4'b0000}) begin
            n_err++;
            $display("FAIL midrar_reset: pc=%h a=%h znch=%b%b%b%b want f000 00 0000",
                     dut.u_cpu.counter_out, dut.u_cpu.a_out, dut.u_cpu.flag_zero_o,
                     dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o, dut.u_cpu.halt);
        end
        sb_q.delete();
        sb_q.push_back('{a: 8'hF0, z: 1'b0, n: 1'b1, c: 1'b0});
        sb_q.push_back('{a: 8'h78, z: 1'b0, n: 1'b1, c: 1'b0});
        load_and_release();
        wait_halt("midrar_rerun", 200);
        n_vec++;
        if ({dut.u_cpu.a_out, dut.u_cpu.counter_out} !== {8'h78, 16'hF004}) begin
            n_err++;
            $display("FAIL midrar_final: a=%h pc=%h want 78 f004",
                     dut.u_cpu.a_out, dut.u_cpu.counter_out);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ldi_rar_hlt();
        test_cycle_timing();
        test_rotate_carry();
        test_sta_lda();
        test_halt_hold();
        test_reset_mid_rar();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
